// File: rtl/mult32x32_fsm.sv
// Sequencer for a 32x32 multiplier built from an 8x16 partial-product unit.
// Optional MULT32X32_FSM_DONE_EN adds a registered one-cycle done pulse.
module mult32x32_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic [1:0] a_sel,
  output logic       b_sel,
  output logic [2:0] shift_sel,
  output logic       upd_prod,
  output logic       clr_prod,
  output logic       done
);

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] A0B0 = 4'd1;
  localparam logic [3:0] A1B0 = 4'd2;
  localparam logic [3:0] A2B0 = 4'd3;
  localparam logic [3:0] A3B0 = 4'd4;
  localparam logic [3:0] A0B1 = 4'd5;
  localparam logic [3:0] A1B1 = 4'd6;
  localparam logic [3:0] A2B1 = 4'd7;
  localparam logic [3:0] A3B1 = 4'd8;

  logic [3:0] state_q, state_d;
  logic       busy_q;

  // busy is registered from the next state so it lines up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign busy = busy_q;

  always_comb begin
    state_d   = IDLE;
    a_sel     = 2'd0;
    b_sel     = 1'b0;
    shift_sel = 3'd0;
    upd_prod  = 1'b0;
    clr_prod  = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so the clear cannot fire while reset holds the block.
        clr_prod = start & reset;
        state_d  = start ? A0B0 : IDLE;
      end
      A0B0: begin
        a_sel = 2'd0; b_sel = 1'b0; shift_sel = 3'd0; upd_prod = 1'b1; state_d = A1B0;
      end
      A1B0: begin
        a_sel = 2'd1; b_sel = 1'b0; shift_sel = 3'd1; upd_prod = 1'b1; state_d = A2B0;
      end
      A2B0: begin
        a_sel = 2'd2; b_sel = 1'b0; shift_sel = 3'd2; upd_prod = 1'b1; state_d = A3B0;
      end
      A3B0: begin
        a_sel = 2'd3; b_sel = 1'b0; shift_sel = 3'd3; upd_prod = 1'b1; state_d = A0B1;
      end
      A0B1: begin
        a_sel = 2'd0; b_sel = 1'b1; shift_sel = 3'd2; upd_prod = 1'b1; state_d = A1B1;
      end
      A1B1: begin
        a_sel = 2'd1; b_sel = 1'b1; shift_sel = 3'd3; upd_prod = 1'b1; state_d = A2B1;
      end
      A2B1: begin
        a_sel = 2'd2; b_sel = 1'b1; shift_sel = 3'd4; upd_prod = 1'b1; state_d = A3B1;
      end
      A3B1: begin
        a_sel = 2'd3; b_sel = 1'b1; shift_sel = 3'd5; upd_prod = 1'b1; state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MULT32X32_FSM_DONE_EN
  logic done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == A3B1);
    end
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

endmodule

// File: tb/tb_mult32x32_fsm.sv
// Directed bench for mult32x32_fsm with a behavioural 8x16 arithmetic unit.
// Done expectations follow MULT32X32_FSM_DONE_EN as compiled.
module tb_mult32x32_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [1:0]  a_sel;
  logic        b_sel;
  logic [2:0]  shift_sel;
  logic        upd_prod;
  logic        clr_prod;
  logic        done;

  logic [31:0] aOp = 32'd0;
  logic [31:0] bOp = 32'd0;
  logic [63:0] prod = 64'd0;
  logic [63:0] partial;

  int checks = 0;
  int errors = 0;

`ifdef MULT32X32_FSM_DONE_EN
  localparam logic DoneEn = 1'b1;
`else
  localparam logic DoneEn = 1'b0;
`endif

  logic [1:0] expA [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic       expB [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [2:0] expS [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd5};

  mult32x32_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .shift_sel (shift_sel),
    .upd_prod  (upd_prod),
    .clr_prod  (clr_prod),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Arithmetic unit: byte of A times 16-bit word of B, shifted by 8*shift_sel.
  always_comb begin
    partial = ({56'd0, aOp[{a_sel, 3'b000} +: 8]} * {48'd0, bOp[{b_sel, 4'b0000} +: 16]})
              << {shift_sel, 3'b000};
  end

  always @(posedge clk) begin
    if (clr_prod) prod <= 64'd0;
    else if (upd_prod) prod <= prod + partial;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, upd_prod, clr_prod, a_sel, b_sel, shift_sel} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b required 0000000000",
               {busy, done, upd_prod, clr_prod, a_sel, b_sel, shift_sel});
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_sequence();
    start = 1'b1;
    #1;
    checks++;
    if (clr_prod !== 1'b1 || upd_prod !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seq_clr: got clr=%b upd=%b required clr=1 upd=0", clr_prod, upd_prod);
    end
    tick();
    start = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (a_sel !== expA[i] || b_sel !== expB[i] || shift_sel !== expS[i]) begin
        errors++;
        $display("[TB] FAIL seq_sel step %0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                 i, a_sel, b_sel, shift_sel, expA[i], expB[i], expS[i]);
      end
      checks++;
      if (upd_prod !== 1'b1 || clr_prod !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL seq_ctrl step %0d: got upd=%b clr=%b busy=%b done=%b required 1 0 1 0",
                 i, upd_prod, clr_prod, busy, done);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || upd_prod !== 1'b0 || done !== DoneEn) begin
      errors++;
      $display("[TB] FAIL seq_end: got busy=%b upd=%b done=%b required busy=0 upd=0 done=%b",
               busy, upd_prod, done, DoneEn);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seq_done_width: got done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_product();
    aOp = 32'hFFFF_FFFF;
    bOp = 32'hFFFF_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    checks++;
    if (prod !== 64'hFFFF_FFFE_0000_0001 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL product_max: got prod=%h busy=%b required FFFFFFFE00000001 busy=0",
               prod, busy);
    end
  endtask

  task automatic test_back_to_back();
    int phase;
    int waitCycles;
    aOp = 32'd3;
    bOp = 32'd5;
    start = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      phase = t % 9;
      if (phase == 8) begin
        checks++;
        if (busy !== 1'b0 || clr_prod !== 1'b1 || prod !== 64'h0000_0000_0000_000F
            || done !== DoneEn) begin
          errors++;
          $display("[TB] FAIL b2b_end t=%0d: got busy=%b clr=%b prod=%h done=%b required 0 1 000000000000000F %b",
                   t, busy, clr_prod, prod, done, DoneEn);
        end
      end else begin
        checks++;
        if (busy !== 1'b1 || upd_prod !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_busy t=%0d: got busy=%b upd=%b done=%b required 1 1 0",
                   t, busy, upd_prod, done);
        end
      end
    end
    start = 1'b0;
    waitCycles = 0;
    while (busy === 1'b1 && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    checks++;
    if (busy !== 1'b0 || prod !== 64'h0000_0000_0000_000F) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got busy=%b prod=%h after %0d cycles required busy=0 prod=000000000000000F",
               busy, prod, waitCycles);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    aOp = 32'h0000_0100;
    bOp = 32'h0001_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    #1;
    checks++;
    if (a_sel !== 2'd2 || clr_prod !== 1'b0) begin
      errors++;
      $display("[TB] FAIL swb_a2b0: got a_sel=%0d clr=%b required 2 0", a_sel, clr_prod);
    end
    tick();
    start = 1'b0;
    #1;
    for (int i = 3; i < 8; i++) begin
      checks++;
      if (a_sel !== expA[i] || b_sel !== expB[i] || shift_sel !== expS[i] || clr_prod !== 1'b0) begin
        errors++;
        $display("[TB] FAIL swb_step %0d: got (%0d,%0d,%0d) clr=%b required (%0d,%0d,%0d) clr=0",
                 i, a_sel, b_sel, shift_sel, clr_prod, expA[i], expB[i], expS[i]);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || prod !== 64'h0000_0000_0100_0000) begin
      errors++;
      $display("[TB] FAIL swb_end: got busy=%b prod=%h required busy=0 prod=0000000001000000",
               busy, prod);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || upd_prod !== 1'b0) begin
      errors++;
      $display("[TB] FAIL swb_no_restart: got busy=%b upd=%b required 0 0", busy, upd_prod);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if (a_sel !== 2'd1 || b_sel !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_a1b1: got a_sel=%0d b_sel=%0d required 1 1", a_sel, b_sel);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, upd_prod, clr_prod, a_sel, b_sel, shift_sel} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got %b required 0000000000",
               {busy, done, upd_prod, clr_prod, a_sel, b_sel, shift_sel});
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || upd_prod !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_no_resume: got busy=%b upd=%b required 0 0", busy, upd_prod);
    end
    aOp = 32'h1234_5678;
    bOp = 32'h0000_0002;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    checks++;
    if (prod !== 64'h0000_0000_2468_ACF0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_product: got prod=%h busy=%b required 000000002468ACF0 busy=0",
               prod, busy);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_sequence();
    test_product();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
